seq_slice_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair one SLICE-bit ripple-carry slice per clock, LSB first, and registers the carry between slices. This is the successor to the fixed 4-bit ripple-carry adder: wide additions reuse a small carry chain instead of one long combinational ripple. It sits behind a valid/ready handshake on both sides, so a datapath can stall it without losing the result.

---
 rtl/seq_slice_adder_pkg.sv | 13 +
 rtl/seq_slice_adder_rca.sv | 46 ++++
 rtl/seq_slice_adder.sv | 112 +++++++++++
 tb/tb_seq_slice_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_slice_adder_pkg.sv
// rtl/seq_slice_adder_pkg.sv - shared state encoding and default geometry for seq_slice_adder
package seq_slice_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_SLICE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_slice_adder_rca.sv
// rtl/seq_slice_adder_rca.sv - full_adder_1 and the N-bit ripple-carry slice adder ripple_carry_adder_n
module full_adder_1 (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   // single-bit sum and majority carry
   always_comb begin
      sum       = a ^ b ^ carry_in;
      carry_out = (a & b) | (a & carry_in) | (b & carry_in);
   end

endmodule

module ripple_carry_adder_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         carry_in,
   output logic [N-1:0] sum,
   output logic         carry_out,
   output logic         msb_carry_in
);

   logic [N:0] carry;

   assign carry[0]     = carry_in;
   assign carry_out    = carry[N];
   // carry entering the top bit, needed by the caller for signed overflow
   assign msb_carry_in = carry[N-1];

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder_1 u_fa (
         .a         (a[i]),
         .b         (b[i]),
         .carry_in  (carry[i]),
         .sum       (sum[i]),
         .carry_out (carry[i+1])
      );
   end

endmodule

// File: rtl/seq_slice_adder.sv
// rtl/seq_slice_adder.sv - multi-cycle slice-serial add/subtract; SEQ_SLICE_ADDER_OVERFLOW_EN adds o_overflow
module seq_slice_adder
   import seq_slice_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_carry_out
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
   ,
   output logic             o_overflow
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   state_t           state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry_reg;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_msb_cin;

   assign slice_a = a_reg[int'(k)*SLICE +: SLICE];
   assign slice_b = b_reg[int'(k)*SLICE +: SLICE];

   ripple_carry_adder_n #(
      .N (SLICE)
   ) u_rca (
      .a            (slice_a),
      .b            (slice_b),
      .carry_in     (carry_reg),
      .sum          (slice_sum),
      .carry_out    (slice_cout),
      .msb_carry_in (slice_msb_cin)
   );

`ifndef SEQ_SLICE_ADDER_OVERFLOW_EN
   logic unused_msb_cin;
   assign unused_msb_cin = slice_msb_cin;
`endif

   // handshake flags come straight from the state register
   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);

   // FSM: capture operands, walk the slices LSB first, hold the result until consumed
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         k           <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         carry_reg   <= 1'b0;
         o_s         <= '0;
         o_carry_out <= 1'b0;
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
         o_overflow  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_reg     <= i_a;
                  b_reg     <= i_sub ? ~i_b : i_b;
                  carry_reg <= i_sub ? 1'b1 : i_carry_in;
                  k         <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               o_s[int'(k)*SLICE +: SLICE] <= slice_sum;
               carry_reg                   <= slice_cout;
               if (k == K_LAST) begin
                  o_carry_out <= slice_cout;
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
                  o_overflow  <= slice_msb_cin ^ slice_cout;
`endif
                  state       <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (i_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_slice_adder.sv
// tb/tb_seq_slice_adder.sv - scoreboard bench for seq_slice_adder (32/4 and 4/4 instances)
module tb_seq_slice_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_ready, i_carry_in, i_sub;
   logic [31:0] i_a, i_b;
   logic        o_ready, o_valid, o_carry_out;
   logic [31:0] o_s;

   logic        n_valid, n_ready, n_cin, n_sub;
   logic [3:0]  n_a, n_b;
   logic        n_o_ready, n_o_valid, n_o_cout;
   logic [3:0]  n_o_s;

`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
   logic        o_overflow, n_o_ovf;
`endif

   int   checks = 0;
   int   errors = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   seq_slice_adder #(.WIDTH(32), .SLICE(4)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_carry_in  (i_carry_in),
      .i_sub       (i_sub),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_s         (o_s),
      .o_carry_out (o_carry_out)
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
      ,
      .o_overflow  (o_overflow)
`endif
   );

   seq_slice_adder #(.WIDTH(4), .SLICE(4)) dut4 (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_valid     (n_valid),
      .o_ready     (n_o_ready),
      .i_a         (n_a),
      .i_b         (n_b),
      .i_carry_in  (n_cin),
      .i_sub       (n_sub),
      .o_valid     (n_o_valid),
      .i_ready     (n_ready),
      .o_s         (n_o_s),
      .o_carry_out (n_o_cout)
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
      ,
      .o_overflow  (n_o_ovf)
`endif
   );

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      res_t        r;
      logic [31:0] bb;
      logic [32:0] t;
      bb  = sub ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
      r.s = t[31:0];
      r.c = t[32];
      r.v = (a[31] == bb[31]) && (t[31] != a[31]);
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
      i_carry_in = 1'b0; i_sub = 1'b0;
      n_valid = 1'b0; n_ready = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", o_ready); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_valid); end
      checks++; if (o_s !== 32'h0) begin errors++; $display("FAIL reset_s got %h want 0", o_s); end
      checks++; if (o_carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b want 0", o_carry_out); end
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
`endif
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input int stall);
      res_t        e;
      logic [31:0] held;
      int          n;
      n = 0;
      while (o_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL wait_ready got %0b want 1", o_ready); end
      @(negedge clk);
      i_valid = 1'b1; i_a = a; i_b = b; i_carry_in = cin; i_sub = sub;
      @(posedge clk);
      sb.push_back(model(a, b, cin, sub));
      #1;
      i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_carry_in = 1'($urandom); i_sub = 1'($urandom);
      if (stall == 0) i_ready = 1'b1;
      n = 0;
      while (o_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++; if (n != 8) begin errors++; $display("FAIL latency got %0d want 8", n); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done got %0b want 0", o_ready); end
      held = o_s;
      for (int j = 0; j < stall; j++) begin
         i_valid = (j % 2 == 0); i_a = $urandom; i_b = $urandom;
         @(posedge clk); #1;
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_s !== held) begin
            errors++;
            $display("FAIL stall_hold valid=%0b ready=%0b s=%h want valid=1 ready=0 s=%h",
                     o_valid, o_ready, o_s, held);
         end
      end
      i_ready = 1'b1; i_valid = 1'b1; i_a = $urandom; i_b = $urandom;
      checks++;
      if (sb.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         if (o_s !== e.s || o_carry_out !== e.c) begin
            errors++;
            $display("FAIL result a=%h b=%h sub=%0b got s=%h c=%0b want s=%h c=%0b",
                     a, b, sub, o_s, o_carry_out, e.s, e.c);
         end
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
         checks++;
         if (o_overflow !== e.v) begin
            errors++; $display("FAIL overflow a=%h b=%h got %0b want %0b", a, b, o_overflow, e.v);
         end
`endif
      end
      @(posedge clk); #1;
      i_valid = 1'b0; i_ready = 1'b0;
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++; $display("FAIL after_handshake ready=%0b valid=%0b want ready=1 valid=0", o_ready, o_valid);
      end
   endtask

   task automatic test_add_carry();
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
      do_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 0);
   endtask

   task automatic test_subtract();
      do_op(32'd5, 32'd7, 1'b0, 1'b1, 0);
      do_op(32'd7, 32'd5, 1'b1, 1'b1, 0);
   endtask

   task automatic test_overflow();
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 5);
      do_op(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1, 0);
   endtask

   task automatic test_abort();
      int seen;
      @(negedge clk);
      i_valid = 1'b1; i_a = 32'hAAAA_AAAA; i_b = 32'h5555_5555; i_carry_in = 1'b1; i_sub = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_s !== 32'h0 || o_carry_out !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL abort_clear s=%h c=%0b valid=%0b want 0 0 0", o_s, o_carry_out, o_valid);
      end
      @(negedge clk); rst = 1'b0;
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         @(posedge clk); #1;
         if (o_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_valid got %0d cycles want 0", seen); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %0b want 1", o_ready); end
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int j = 0; j < 6; j++) begin
         do_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_narrow();
      int n;
      @(negedge clk);
      n_valid = 1'b1; n_a = 4'hF; n_b = 4'h1; n_cin = 1'b1; n_sub = 1'b0;
      @(posedge clk); #1;
      n_valid = 1'b0; n_a = 4'h0; n_b = 4'h0;
      n = 0;
      while (n_o_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (n != 1) begin errors++; $display("FAIL narrow_latency got %0d want 1", n); end
      checks++;
      if (n_o_s !== 4'h1 || n_o_cout !== 1'b1) begin
         errors++; $display("FAIL narrow_result got s=%h c=%0b want s=1 c=1", n_o_s, n_o_cout);
      end
`ifdef SEQ_SLICE_ADDER_OVERFLOW_EN
      checks++; if (n_o_ovf !== 1'b0) begin errors++; $display("FAIL narrow_ovf got %0b want 0", n_o_ovf); end
`endif
      n_ready = 1'b1;
      @(posedge clk); #1;
      n_ready = 1'b0;
      checks++; if (n_o_ready !== 1'b1) begin errors++; $display("FAIL narrow_ready got %0b want 1", n_o_ready); end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_carry();
      test_subtract();
      test_overflow();
      test_backpressure();
      test_abort();
      test_random();
      test_narrow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
